// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester round-robin arbiter for the external memory port
// One memory transaction at a time, with an ack timeout so a dead memory cannot hang a requester.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s0_req,
   input  logic                  s0_we,
   input  logic [ADDR_WIDTH-1:0] s0_addr,
   input  logic [DATA_WIDTH-1:0] s0_wdata,
   output logic                  s0_ack,
   output logic                  s0_err,
   output logic [DATA_WIDTH-1:0] s0_rdata,
   input  logic                  s1_req,
   input  logic                  s1_we,
   input  logic [ADDR_WIDTH-1:0] s1_addr,
   input  logic [DATA_WIDTH-1:0] s1_wdata,
   output logic                  s1_ack,
   output logic                  s1_err,
   output logic [DATA_WIDTH-1:0] s1_rdata,
   output logic                  m_cyc,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic                  m_ack,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  busy
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TERM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state, state_n;
   logic                  owner, owner_n;
   logic                  last_grant, last_grant_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  cyc_n, we_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] wdata_n;
   logic                  ack0_n, ack1_n, err0_n, err1_n;
   logic [DATA_WIDTH-1:0] rdata0_n, rdata1_n;
   logic                  elig0, elig1, grant1;

   // A requester still holding req during its own ack/err cycle must not re-issue.
   assign elig0  = s0_req & ~s0_ack & ~s0_err;
   assign elig1  = s1_req & ~s1_ack & ~s1_err;
   assign grant1 = elig1 & (~elig0 | ~last_grant);
   assign busy   = (state == BUSY);

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_grant_n = last_grant;
      cnt_n        = cnt;
      cyc_n        = m_cyc;
      we_n         = m_we;
      addr_n       = m_addr;
      wdata_n      = m_wdata;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      err0_n       = 1'b0;
      err1_n       = 1'b0;
      rdata0_n     = s0_rdata;
      rdata1_n     = s1_rdata;
      case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               state_n = BUSY;
               owner_n = grant1;
               cnt_n   = '0;
               cyc_n   = 1'b1;
               we_n    = grant1 ? s1_we    : s0_we;
               addr_n  = grant1 ? s1_addr  : s0_addr;
               wdata_n = grant1 ? s1_wdata : s0_wdata;
            end
         end
         BUSY: begin
            if (m_ack) begin
               if (!m_we) begin
                  if (owner) rdata1_n = m_rdata;
                  else       rdata0_n = m_rdata;
               end
               ack0_n       = ~owner;
               ack1_n       = owner;
               cyc_n        = 1'b0;
               last_grant_n = owner;
               state_n      = IDLE;
            end else if ((TIMEOUT != 0) && (cnt == TERM)) begin
               err0_n       = ~owner;
               err1_n       = owner;
               cyc_n        = 1'b0;
               last_grant_n = owner;
               state_n      = IDLE;
            end else if (cnt != '1) begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         m_cyc      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         s0_ack     <= 1'b0;
         s0_err     <= 1'b0;
         s1_ack     <= 1'b0;
         s1_err     <= 1'b0;
         s0_rdata   <= '0;
         s1_rdata   <= '0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         last_grant <= last_grant_n;
         cnt        <= cnt_n;
         m_cyc      <= cyc_n;
         m_we       <= we_n;
         m_addr     <= addr_n;
         m_wdata    <= wdata_n;
         s0_ack     <= ack0_n;
         s0_err     <= err0_n;
         s1_ack     <= ack1_n;
         s1_err     <= err1_n;
         s0_rdata   <= rdata0_n;
         s1_rdata   <= rdata1_n;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
// Directed vector table, reset/arbitration sequences, and a randomized run against a transaction model.
module tb_mem_bus_arbiter;

   localparam int AW = 24;
   localparam int DW = 8;
   localparam int TO = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s0_req = 0, s0_we = 0, s1_req = 0, s1_we = 0;
   logic [AW-1:0] s0_addr = '0, s1_addr = '0;
   logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
   logic s0_ack, s0_err, s1_ack, s1_err;
   logic [DW-1:0] s0_rdata, s1_rdata;
   logic m_cyc, m_we, busy;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic m_ack = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
      .s0_ack(s0_ack), .s0_err(s0_err), .s0_rdata(s0_rdata),
      .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
      .s1_ack(s1_ack), .s1_err(s1_err), .s1_rdata(s1_rdata),
      .m_cyc(m_cyc), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic get_ack(input int r);
      return (r != 0) ? s1_ack : s0_ack;
   endfunction
   function automatic logic get_err(input int r);
      return (r != 0) ? s1_err : s0_err;
   endfunction
   function automatic logic [DW-1:0] get_rdata(input int r);
      return (r != 0) ? s1_rdata : s0_rdata;
   endfunction

   task automatic drive(input int r, input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (r != 0) begin s1_req = rq; s1_we = we; s1_addr = a; s1_wdata = d; end
      else        begin s0_req = rq; s0_we = we; s0_addr = a; s0_wdata = d; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      m_ack = 1'b0;
      m_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int            sel;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            delay;   // m_cyc cycles before m_ack; >= TO means never
      logic [DW-1:0] mdata;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   // One transaction through the arbiter; requester holds req through its ack/err cycle.
   task automatic run_vec(input vec_t v);
      int waitc, cyc_cnt, steps;
      logic got_ack, got_err, other;
      drive(v.sel, 1, v.we, v.addr, v.wdata);
      @(negedge clk);
      waitc = 0;
      while (!m_cyc && waitc < 4) begin @(negedge clk); waitc++; end
      check("grant_latency", waitc, 0);
      check("m_addr", m_addr, v.addr);
      check("m_we", m_we, v.we);
      if (v.we) check("m_wdata", m_wdata, v.wdata);
      cyc_cnt = 1; got_ack = 0; got_err = 0; other = 0; steps = 0;
      while (!got_ack && !got_err && steps < 40) begin
         if (cyc_cnt - 1 == v.delay) begin m_ack = 1'b1; m_rdata = v.mdata; end
         else begin m_ack = 1'b0; m_rdata = 8'($urandom); end
         @(negedge clk);
         m_ack = 1'b0;
         steps++;
         got_ack = get_ack(v.sel);
         got_err = get_err(v.sel);
         other = other | get_ack(1 - v.sel) | get_err(1 - v.sel);
         if (m_cyc) cyc_cnt++;
      end
      check("vec_done_in_budget", (steps < 40), 1);
      check("vec_ack", got_ack, !v.exp_err);
      check("vec_err", got_err, v.exp_err);
      check("vec_cyc_len", cyc_cnt, v.exp_err ? TO : v.delay + 1);
      check("vec_rdata", get_rdata(v.sel), v.exp_rdata);
      check("vec_other_quiet", other, 0);
      check("vec_mcyc_drop", m_cyc, 0);
      check("vec_busy_drop", busy, 0);
      @(negedge clk);
      check("mask_no_reissue", m_cyc, 0);
      check("pulse_single", get_ack(v.sel) | get_err(v.sel), 0);
      drive(v.sel, 0, 0, '0, '0);
   endtask

   // Randomized run: model state is kept in transaction terms (who owns the port, how long it has waited).
   task automatic random_run(input int ncyc);
      logic rq[2], wq[2];
      logic [AW-1:0] aq[2];
      logic [DW-1:0] dq[2];
      logic e_ack[2], e_err[2], n_ack[2], n_err[2];
      logic [DW-1:0] e_rd[2];
      logic e_cyc, own, lastg, c_we, el0, el1;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wdata;
      int age;
      for (int r = 0; r < 2; r++) begin
         rq[r] = 0; wq[r] = 0; aq[r] = '0; dq[r] = '0;
         e_ack[r] = 0; e_err[r] = 0; e_rd[r] = '0;
      end
      e_cyc = 0; own = 0; lastg = 1; age = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         check("rnd_m_cyc", m_cyc, e_cyc);
         check("rnd_busy", busy, e_cyc);
         check("rnd_s0_ack", s0_ack, e_ack[0]);
         check("rnd_s1_ack", s1_ack, e_ack[1]);
         check("rnd_s0_err", s0_err, e_err[0]);
         check("rnd_s1_err", s1_err, e_err[1]);
         check("rnd_s0_rdata", s0_rdata, e_rd[0]);
         check("rnd_s1_rdata", s1_rdata, e_rd[1]);
         if (e_cyc) begin
            check("rnd_m_addr", m_addr, c_addr);
            check("rnd_m_we", m_we, c_we);
            check("rnd_m_wdata", m_wdata, c_wdata);
         end
         for (int r = 0; r < 2; r++) begin
            if ((e_ack[r] || e_err[r] || !rq[r]) && ($urandom_range(3, 0) == 0 || (rq[r] && $urandom_range(1, 0) == 0))) begin
               rq[r] = 1; wq[r] = 1'($urandom); aq[r] = 24'($urandom); dq[r] = 8'($urandom);
            end else if (e_ack[r] || e_err[r]) begin
               rq[r] = 0;
            end
            drive(r, rq[r], wq[r], aq[r], dq[r]);
         end
         m_ack = e_cyc ? ($urandom_range(4, 0) == 0) : ($urandom_range(7, 0) == 0);
         m_rdata = 8'($urandom);
         n_ack[0] = 0; n_ack[1] = 0; n_err[0] = 0; n_err[1] = 0;
         if (e_cyc) begin
            if (m_ack) begin
               n_ack[own] = 1;
               if (!c_we) e_rd[own] = m_rdata;
               e_cyc = 0; lastg = own;
            end else if (age == TO) begin
               n_err[own] = 1;
               e_cyc = 0; lastg = own;
            end else begin
               age++;
            end
         end else begin
            el0 = rq[0] && !e_ack[0] && !e_err[0];
            el1 = rq[1] && !e_ack[1] && !e_err[1];
            if (el0 || el1) begin
               own = (el0 && el1) ? !lastg : el1;
               e_cyc = 1; age = 1;
               c_we = wq[own]; c_addr = aq[own]; c_wdata = dq[own];
            end
         end
         e_ack = n_ack;
         e_err = n_err;
      end
      @(negedge clk);
      m_ack = 1'b0;
   endtask

   initial begin
      vec_t vecs[7];
      logic grants[$];
      int a0, a1, both, errs, steps;
      logic prev_cyc;

      vecs[0] = '{0, 1'b0, 24'h000123, 8'h00, 2,  8'hA5, 1'b0, 8'hA5};
      vecs[1] = '{1, 1'b1, 24'h00FFFF, 8'h3C, 99, 8'h00, 1'b1, 8'h00};
      vecs[2] = '{0, 1'b1, 24'h000456, 8'h77, 0,  8'h11, 1'b0, 8'hA5};
      vecs[3] = '{1, 1'b0, 24'h000010, 8'h00, TO - 1, 8'h5E, 1'b0, 8'h5E};
      vecs[4] = '{1, 1'b0, 24'h000020, 8'h00, TO, 8'h99, 1'b1, 8'h5E};
      vecs[5] = '{0, 1'b0, 24'hFFFFFF, 8'h00, 0,  8'hC3, 1'b0, 8'hC3};
      vecs[6] = '{1, 1'b1, 24'h00ABCD, 8'hE1, 3,  8'h44, 1'b0, 8'h5E};

      do_reset();
      @(negedge clk);
      check("rst_m_cyc", m_cyc, 0);
      check("rst_busy", busy, 0);
      check("rst_acks", {s0_ack, s1_ack, s0_err, s1_err}, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_rdata", {s0_rdata, s1_rdata}, 0);

      // Both requesters held from the same edge, three transactions each.
      drive(0, 1, 0, 24'h000100, 8'h00);
      drive(1, 1, 0, 24'h000200, 8'h00);
      a0 = 0; a1 = 0; both = 0; errs = 0; prev_cyc = 0; steps = 0;
      while (a0 + a1 < 6 && steps < 80) begin
         @(negedge clk);
         steps++;
         if (m_cyc && !prev_cyc) grants.push_back(m_addr == 24'h000200);
         prev_cyc = m_cyc;
         if (s0_ack && s1_ack) both++;
         if (s0_err || s1_err) errs++;
         if (s0_ack) begin a0++; if (a0 == 3) s0_req = 0; end
         if (s1_ack) begin a1++; if (a1 == 3) s1_req = 0; end
         m_ack = m_cyc;
      end
      m_ack = 1'b0;
      check("rr_grant_count", grants.size(), 6);
      for (int i = 0; i < grants.size(); i++) check("rr_grant_order", grants[i], i % 2);
      check("rr_s0_acks", a0, 3);
      check("rr_s1_acks", a1, 3);
      check("rr_overlap", both, 0);
      check("rr_errs", errs, 0);
      @(negedge clk);
      check("rr_idle_after", m_cyc, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Async reset mid-transaction; the owner is s1 and s0 last completed.
      run_vec('{0, 1'b0, 24'h000777, 8'h00, 0, 8'h12, 1'b0, 8'h12});
      drive(1, 1, 0, 24'h0ABCDE, 8'h00);
      @(negedge clk);
      check("rstmid_granted", m_cyc, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rstmid_m_cyc_async", m_cyc, 0);
      check("rstmid_busy_async", busy, 0);
      check("rstmid_no_pulse", {s0_ack, s1_ack, s0_err, s1_err}, 0);
      drive(1, 0, 0, '0, '0);
      @(negedge clk);
      m_ack = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("stray_ack_ignored", {m_cyc, s0_ack, s1_ack, s0_err, s1_err}, 0);
      m_ack = 1'b0;
      drive(0, 1, 0, 24'h000111, 8'h00);
      drive(1, 1, 0, 24'h000222, 8'h00);
      @(negedge clk);
      check("post_rst_first_s0", m_addr, 24'h000111);
      m_ack = 1'b1; m_rdata = 8'h6B;
      @(negedge clk);
      m_ack = 1'b0;
      check("post_rst_s0_ack", {s0_ack, s1_ack}, 2'b10);
      check("post_rst_s0_rdata", s0_rdata, 8'h6B);
      s0_req = 1'b0;
      @(negedge clk);
      check("post_rst_second_s1", {m_cyc, m_addr}, {1'b1, 24'h000222});
      m_ack = 1'b1;
      @(negedge clk);
      m_ack = 1'b0;
      check("post_rst_s1_ack", {s0_ack, s1_ack}, 2'b01);
      s1_req = 1'b0;
      @(negedge clk);

      do_reset();
      random_run(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
